fetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle core; sits directly upstream of the instruction memory.
- Owns the word-addressed program counter and drives it as pc_out to the memory's pc_in.
- Samples the combinationally returned instruction word into a 2-entry buffer.
- Presents instructions to decode with a valid/ready handshake; accepts branch redirects from execute.

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Decode-side handshake between the fetch stage and decode.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              dec_valid_out;
  logic              dec_ready_in;
  logic [31:0]       dec_instr_out;
  logic [ADDR_W-1:0] dec_pc_out;

  modport master (
    output dec_valid_out,
    output dec_instr_out,
    output dec_pc_out,
    input  dec_ready_in
  );

  modport slave (
    input  dec_valid_out,
    input  dec_instr_out,
    input  dec_pc_out,
    output dec_ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC owner, 2-entry {pc, instr} buffer toward decode, branch redirect.
// Optional macro FETCH_PERF_CNT_EN adds saturating pop and flush counters.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned LAST_PC  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [31:0]       instr_in,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_pc_in,
  fetch_unit_if.master      dec,
  output logic              busy_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_out,
  output logic [15:0]       flush_cnt_out
`endif
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            e0_q, e0_d, e1_q, e1_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              pop;
  logic              flush;
  logic              fetch;
  entry_t            new_e;

  assign pop   = (count_q != CNT_W'(0)) && dec.dec_ready_in;
  assign flush = redirect_in && (state_q != IDLE);
  assign fetch = (state_q == RUN) && !redirect_in && ((count_q < CNT_W'(2)) || pop);
  assign new_e = '{pc: pc_q, instr: instr_in};

  // Next-state: redirect pre-empts start, fetch and pop alike.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;

    if (flush) begin
      state_d = RUN;
      pc_d    = redirect_pc_in;
      count_d = CNT_W'(0);
    end else begin
      unique case (state_q)
        IDLE: if (start_in) state_d = RUN;
        HALT: if (start_in) begin
          state_d = RUN;
          pc_d    = ADDR_W'(RESET_PC);
        end
        RUN: if (fetch) begin
          pc_d = pc_q + ADDR_W'(1);
          if (pc_q == ADDR_W'(LAST_PC)) state_d = HALT;
        end
        default: state_d = IDLE;
      endcase

      // Head always lives in e0 so the decode outputs come straight from flops.
      unique case ({pop, fetch})
        2'b01: begin
          if (count_q == CNT_W'(0)) e0_d = new_e;
          else                      e1_d = new_e;
          count_d = count_q + CNT_W'(1);
        end
        2'b10: begin
          e0_d    = e1_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            e0_d = new_e;
          end else begin
            e0_d = e1_q;
            e1_d = new_e;
          end
        end
        default: ;
      endcase
    end

    valid_d = (count_d != CNT_W'(0));
    busy_d  = (state_d == RUN) || (count_d != CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      count_q <= CNT_W'(0);
      e0_q    <= '0;
      e1_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign pc_out            = pc_q;
  assign busy_out          = busy_q;
  assign dec.dec_valid_out = valid_q;
  assign dec.dec_instr_out = e0_q.instr;
  assign dec.dec_pc_out    = e0_q.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  // A pop coinciding with a redirect is discarded, so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (pop && !flush && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush && (count_q != CNT_W'(0)) && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt_out = fetch_cnt_q;
  assign flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instance A (LAST_PC=255) and instance B (LAST_PC=3) share stimulus.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] pc_a, pc_b;
  logic [31:0]       instr_a, instr_b;
  logic              busy_a, busy_b;

  int checks;
  int errors;

  fetch_unit_if #(.ADDR_W(ADDR_W)) if_a ();
  fetch_unit_if #(.ADDR_W(ADDR_W)) if_b ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_a, fcnt_b;
  logic [15:0] flcnt_a, flcnt_b;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(0), .LAST_PC(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_in(start), .pc_out(pc_a), .instr_in(instr_a),
    .redirect_in(redirect), .redirect_pc_in(redirect_pc), .dec(if_a.master), .busy_out(busy_a)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_out(fcnt_a), .flush_cnt_out(flcnt_a)
`endif
  );

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(0), .LAST_PC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_in(start), .pc_out(pc_b), .instr_in(instr_b),
    .redirect_in(redirect), .redirect_pc_in(redirect_pc), .dec(if_b.master), .busy_out(busy_b)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_out(fcnt_b), .flush_cnt_out(flcnt_b)
`endif
  );

  function automatic logic [31:0] mem(input logic [ADDR_W-1:0] a);
    case (a)
      8'd0:    mem = 32'h0401_0000;
      8'd1:    mem = 32'h0021_1000;
      default: mem = 32'hA000_0000 | {24'd0, a};
    endcase
  endfunction

  assign instr_a = mem(pc_a);
  assign instr_b = mem(pc_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = '0;
    if_a.dec_ready_in = 1'b0; if_b.dec_ready_in = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, if_a.dec_valid_out}, 32'd0);
    check("rst_pc",    {24'd0, pc_a}, 32'd0);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_instr", if_a.dec_instr_out, 32'd0);
    check("rst_decpc", {24'd0, if_a.dec_pc_out}, 32'd0);
    rst_n = 1'b1;

    // 1: streaming with decode always ready
    start = 1'b1; if_a.dec_ready_in = 1'b1; if_b.dec_ready_in = 1'b1;
    tick(); start = 1'b0;
    check("t1_valid_k",  {31'd0, if_a.dec_valid_out}, 32'd0);
    check("t1_busy_k",   {31'd0, busy_a}, 32'd1);
    tick();
    check("t1_valid0",   {31'd0, if_a.dec_valid_out}, 32'd1);
    check("t1_decpc0",   {24'd0, if_a.dec_pc_out}, 32'd0);
    check("t1_instr0",   if_a.dec_instr_out, 32'h0401_0000);
    tick();
    check("t1_decpc1",   {24'd0, if_a.dec_pc_out}, 32'd1);
    check("t1_instr1",   if_a.dec_instr_out, 32'h0021_1000);
    check("t1_pc",       {24'd0, pc_a}, 32'd2);
    tick();
    check("t1_decpc2",   {24'd0, if_a.dec_pc_out}, 32'd2);
    check("t1_instr2",   if_a.dec_instr_out, 32'hA000_0002);

    // 2: backpressure fills the buffer, then drains in order
    do_reset();
    if_a.dec_ready_in = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check("t2_pc_hold",  {24'd0, pc_a}, 32'd2);
    check("t2_head",     {24'd0, if_a.dec_pc_out}, 32'd0);
    check("t2_valid",    {31'd0, if_a.dec_valid_out}, 32'd1);
    tick();
    check("t2_pc_hold2", {24'd0, pc_a}, 32'd2);
    check("t2_head2",    {24'd0, if_a.dec_pc_out}, 32'd0);
    if_a.dec_ready_in = 1'b1;
    tick();
    check("t2_drain1",   {24'd0, if_a.dec_pc_out}, 32'd1);
    tick();
    check("t2_drain2",   {24'd0, if_a.dec_pc_out}, 32'd2);
    tick(); tick(); tick(); tick();
    check("t2_head6",    {24'd0, if_a.dec_pc_out}, 32'd6);
    check("t2_pc8",      {24'd0, pc_a}, 32'd8);

    // 3: redirect with a pop pending flushes entries 6,7
    redirect = 1'b1; redirect_pc = 8'd0;
    tick(); redirect = 1'b0;
    check("t3_flush_v",  {31'd0, if_a.dec_valid_out}, 32'd0);
    check("t3_pc",       {24'd0, pc_a}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("t3_flushcnt", {16'd0, flcnt_a}, 32'd1);
`endif
    tick();
    check("t3_valid",    {31'd0, if_a.dec_valid_out}, 32'd1);
    check("t3_decpc",    {24'd0, if_a.dec_pc_out}, 32'd0);

    // 4: LAST_PC=3 on instance B
    do_reset();
    if_b.dec_ready_in = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("t4_dec0",     {24'd0, if_b.dec_pc_out}, 32'd0);
    tick(); tick(); tick();
    check("t4_dec3",     {24'd0, if_b.dec_pc_out}, 32'd3);
    check("t4_pc4",      {24'd0, pc_b}, 32'd4);
    check("t4_busy_h",   {31'd0, busy_b}, 32'd1);
    tick();
    check("t4_empty",    {31'd0, if_b.dec_valid_out}, 32'd0);
    check("t4_busy_low", {31'd0, busy_b}, 32'd0);
    tick();
    check("t4_pc_stay",  {24'd0, pc_b}, 32'd4);
    check("t4_nofetch",  {31'd0, if_b.dec_valid_out}, 32'd0);
    redirect = 1'b1; redirect_pc = 8'd1;
    tick(); redirect = 1'b0;
    check("t4_rd_pc",    {24'd0, pc_b}, 32'd1);
    check("t4_rd_busy",  {31'd0, busy_b}, 32'd1);
    tick();
    check("t4_resume_v", {31'd0, if_b.dec_valid_out}, 32'd1);
    check("t4_resume",   {24'd0, if_b.dec_pc_out}, 32'd1);

    // 5: asynchronous reset with a full buffer on instance A
    if_a.dec_ready_in = 1'b0;
    tick(); tick();
    check("t5_full_v",   {31'd0, if_a.dec_valid_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_v",  {31'd0, if_a.dec_valid_out}, 32'd0);
    check("t5_async_pc", {24'd0, pc_a}, 32'd0);
    check("t5_async_b",  {31'd0, busy_a}, 32'd0);
    #1 rst_n = 1'b1;
    if_a.dec_ready_in = 1'b1;
    tick(); tick(); tick();
    check("t5_idle_v",   {31'd0, if_a.dec_valid_out}, 32'd0);
    check("t5_idle_pc",  {24'd0, pc_a}, 32'd0);

    // 6: redirect in IDLE is ignored
    redirect = 1'b1; redirect_pc = 8'd5;
    tick(); redirect = 1'b0;
    check("t6_pc",       {24'd0, pc_a}, 32'd0);
    check("t6_busy",     {31'd0, busy_a}, 32'd0);
    tick();
    check("t6_valid",    {31'd0, if_a.dec_valid_out}, 32'd0);
    check("t6_pc2",      {24'd0, pc_a}, 32'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("t6_start_pc", {24'd0, if_a.dec_pc_out}, 32'd0);
    check("t6_start_v",  {31'd0, if_a.dec_valid_out}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
